// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle for serial_subtractor
//
// Purpose: groups the operation handshake, operands and result of the
//          bit-serial subtractor.
// Signals:
//   start  request an operation (driven by master)
//   A, B   minuend / subtrahend, WIDTH bits (driven by master)
//   busy   high while bits are being processed (driven by slave)
//   done   one-cycle pulse when Diff/Bo have just updated (driven by slave)
//   Diff   A - B modulo 2^WIDTH (driven by slave)
//   Bo     final borrow, 1 iff A < B (driven by slave)
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bo;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Bo
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Bo
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B, LSB first, with registered borrow
//
// Purpose: computes A - B one bit per clock over WIDTH cycles, framed by a
//          start/busy/done handshake; Diff/Bo hold the last completed result.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    serial_subtractor_if.slave (start, A, B in; busy, done, Diff, Bo out)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic [WIDTH-1:0] diff_q;
  logic             br;
  logic             bo_q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_bit;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] sd_next;

  always_comb begin
    accept   = (state == IDLE) && bus.start;
    last_bit = (state == RUN) && (cnt == LAST);
    d        = sa[0] ^ sb[0] ^ br;
    br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    // New difference bit enters at the MSB so that after WIDTH shifts the
    // first (LSB) bit has reached bit 0.
    sd_next  = (sd >> 1) | {d, {(WIDTH-1){1'b0}}};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      sd     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bo_q   <= 1'b0;
    end else if (accept) begin
      sa  <= bus.A;
      sb  <= bus.B;
      sd  <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sd  <= sd_next;
      br  <= br_next;
      cnt <= cnt + CNT_W'(1);
      // Published result only moves on the final bit, so LEDs never show a
      // partial difference.
      if (last_bit) begin
        diff_q <= sd_next;
        bo_q   <= br_next;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.Diff = diff_q;
  assign bus.Bo   = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH 8, 4 and 2
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int checks = 0;
  int errors = 0;

  serial_subtractor_if #(.WIDTH(8)) if8();
  serial_subtractor_if #(.WIDTH(4)) if4();
  serial_subtractor_if #(.WIDTH(2)) if2();

  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_subtractor #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [2:0] q2[$];

  logic [7:0] last_diff;
  logic       last_bo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitors: pop the expected result whenever a DUT presents done.
  always @(negedge clk) begin
    if (rst_n && if8.done) begin
      if (q8.size() == 0) begin
        fail_now("unexpected_done8");
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        chk("diff8", 32'(if8.Diff), 32'(e[7:0]));
        chk("bo8", 32'(if8.Bo), 32'(e[8]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if4.done) begin
      if (q4.size() == 0) begin
        fail_now("unexpected_done4");
      end else begin
        logic [4:0] e;
        e = q4.pop_front();
        chk("diff4", 32'(if4.Diff), 32'(e[3:0]));
        chk("bo4", 32'(if4.Bo), 32'(e[4]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if2.done) begin
      if (q2.size() == 0) begin
        fail_now("unexpected_done2");
      end else begin
        logic [2:0] e;
        e = q2.pop_front();
        chk("diff2", 32'(if2.Diff), 32'(e[1:0]));
        chk("bo2", 32'(if2.Bo), 32'(e[2]));
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while ((if8.busy || if8.done) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) fail_now("wait_idle8");
  endtask

  // One framed operation with hand-computed expected result, plus latency,
  // pulse-width and result-hold checks.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb);
    int n;
    int acc;
    wait_idle8();
    if8.start = 1'b1;
    if8.A     = a;
    if8.B     = b;
    @(negedge clk);
    chk("accept8", 32'(if8.busy), 32'd1);
    acc = edge_cnt;
    q8.push_back({eb, ed});
    if8.start = 1'b0;
    if8.A     = 8'($urandom);
    if8.B     = 8'($urandom);
    n = 0;
    while (if8.busy && n < 40) begin
      chk("hold_diff", 32'(if8.Diff), 32'(last_diff));
      chk("hold_bo", 32'(if8.Bo), 32'(last_bo));
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'd8);
    chk("done_pulse", 32'(if8.done), 32'd1);
    chk("done_edge", 32'(edge_cnt - acc), 32'd8);
    @(negedge clk);
    chk("done_width", 32'(if8.done), 32'd0);
    last_diff = ed;
    last_bo   = eb;
  endtask

  initial begin
    int n;
    int seen;
    int acc[3];

    rst_n = 1'b0;
    if8.start = 1'b0; if8.A = '0; if8.B = '0;
    if4.start = 1'b0; if4.A = '0; if4.B = '0;
    if2.start = 1'b0; if2.A = '0; if2.B = '0;
    last_diff = 8'd0;
    last_bo   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(if8.busy), 32'd0);
    chk("rst_done", 32'(if8.done), 32'd0);
    chk("rst_diff", 32'(if8.Diff), 32'd0);
    chk("rst_bo", 32'(if8.Bo), 32'd0);
    rst_n = 1'b1;

    run_op(8'd100, 8'd37,  8'd63,  1'b0);
    run_op(8'd37,  8'd100, 8'd193, 1'b1);
    run_op(8'd0,   8'd1,   8'd255, 1'b1);
    run_op(8'd255, 8'd255, 8'd0,   1'b0);

    // Start held high: accepts every WIDTH+2 edges; A/B disturbed mid-run.
    wait_idle8();
    if8.start = 1'b1;
    if8.A = 8'd200;
    if8.B = 8'd55;
    for (int op = 0; op < 3; op++) begin
      n = 0;
      while (!if8.busy && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("held_accept", 32'(if8.busy), 32'd1);
      acc[op] = edge_cnt;
      q8.push_back({1'b0, 8'd145});
      if8.A = 8'd17;
      if8.B = 8'd99;
      n = 0;
      while (!if8.done && n < 20) begin
        n++;
        @(negedge clk);
      end
      if (n >= 20) fail_now("held_done");
      if8.A = 8'd200;
      if8.B = 8'd55;
      if (op == 2) if8.start = 1'b0;
    end
    chk("accept_gap1", 32'(acc[1] - acc[0]), 32'd10);
    chk("accept_gap2", 32'(acc[2] - acc[0]), 32'd20);
    last_diff = 8'd145;
    last_bo   = 1'b0;

    // Result hold across a following operation.
    run_op(8'd100, 8'd37, 8'd63,  1'b0);
    run_op(8'd10,  8'd20, 8'd246, 1'b1);

    // Reset four cycles into RUN discards the operation.
    wait_idle8();
    if8.start = 1'b1;
    if8.A = 8'd9;
    if8.B = 8'd3;
    @(negedge clk);
    chk("rst_test_accept", 32'(if8.busy), 32'd1);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(if8.busy), 32'd0);
    chk("midrst_done", 32'(if8.done), 32'd0);
    chk("midrst_diff", 32'(if8.Diff), 32'd0);
    chk("midrst_bo", 32'(if8.Bo), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done) seen++;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    last_diff = 8'd0;
    last_bo   = 1'b0;
    run_op(8'd9, 8'd3, 8'd6, 1'b0);

    // Exhaustive back-to-back sweep at WIDTH=4.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        n = 0;
        while ((if4.busy || if4.done) && n < 20) begin
          n++;
          @(negedge clk);
        end
        if (n >= 20) fail_now("wait_idle4");
        if4.start = 1'b1;
        if4.A = 4'(a);
        if4.B = 4'(b);
        @(negedge clk);
        chk("accept4", 32'(if4.busy), 32'd1);
        q4.push_back({(a < b), 4'(a - b)});
        if4.start = 1'b0;
      end
    end
    n = 0;
    while (q4.size() != 0 && n < 20) begin
      n++;
      @(negedge clk);
    end

    // WIDTH=2 corner: 1 - 2.
    if2.start = 1'b1;
    if2.A = 2'd1;
    if2.B = 2'd2;
    @(negedge clk);
    chk("accept2", 32'(if2.busy), 32'd1);
    q2.push_back({1'b1, 2'd3});
    if2.start = 1'b0;
    n = 0;
    while (q2.size() != 0 && n < 20) begin
      n++;
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor that computes A − B one bit per clock, LSB first, using a registered borrow. It is the inverse-operation companion to the team's combinational adder blocks. It is the subtract datapath for the Nexys 4 DDR arithmetic demos, driven from switch/button logic, with results shown on LEDs. A start/busy/done handshake frames each operation, and results are held stable until the next completed operation.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request an operation; sampled only in IDLE
- A  input  WIDTH  minuend; sampled on the accepting edge only
- B  input  WIDTH  subtrahend; sampled on the accepting edge only
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse: Diff/Bo just updated
- Diff  output  WIDTH  A − B modulo 2^WIDTH, registered
- Bo  output  1  final borrow out; 1 iff A < B (unsigned)

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on a rising edge with start=1.
  - RUN → DONE on the edge that processes bit WIDTH−1.
  - DONE → IDLE unconditionally on the next edge.
- Accept edge:
  - Load A and B into shift registers sa and sb.
  - Clear the borrow register br and the bit counter cnt.
  - Clear the internal difference shift register sd.
- Each RUN edge:
  - d = sa[0] ^ sb[0] ^ br.
  - br ← (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - sa and sb shift right by 1.
  - sd shifts right with d inserted at the MSB.
  - cnt increments.
- Last RUN edge (cnt = WIDTH−1):
  - Diff ← final sd value, including this edge's d.
  - Bo ← final br value.
  - Enter DONE.
- Outputs:
  - busy = (state == RUN).
  - done = (state == DONE).
- Diff and Bo change only on the last RUN edge. They hold the previous result throughout RUN, DONE and IDLE.
- start is ignored in RUN and DONE. No queuing: a start held high through DONE is accepted on the first edge back in IDLE.
- A and B may change freely after the accept edge.
- Width rules: cnt is ceil(log2(WIDTH)) bits wide. Arithmetic is unsigned, modulo 2^WIDTH.

## Timing
- Reset (asynchronous assert, any time, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, Diff=0, Bo=0.
  - sa, sb, sd, br and cnt are all cleared.
  - The in-flight operation is discarded, with no done pulse.
- Reset deassert: the first rising edge with rst_n=1 can accept start.
- Latency, for start accepted at edge k:
  - busy=1 from after edge k until edge k+WIDTH.
  - Diff/Bo update at edge k+WIDTH.
  - done=1 for the single cycle between edges k+WIDTH and k+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is edge k+WIDTH+2.
- Outputs are glitch-free registered values, except busy and done, which are decoded from the state register only.

## Test plan
- WIDTH=8, A=100, B=37, start pulse → busy for 8 cycles, done pulse at edge k+8, Diff=63, Bo=0.
- A=37, B=100 → Diff=193, Bo=1. Then A=0, B=1 → Diff=255, Bo=1. Then A=255, B=255 → Diff=0, Bo=0.
- Start held high continuously with A=200, B=55 → Diff=145, Bo=0. Accepts occur at edges 0, 10 and 20. Exactly one done pulse per operation; start during RUN/DONE has no effect. Changing A/B during RUN does not alter the result.
- Result hold: after Diff=63, start A=10, B=20 → Diff stays 63 during RUN, then becomes 246 with Bo=1 at done.
- Reset pulse asserted 4 cycles into RUN (A=9, B=3) → busy, done, Diff and Bo drop to 0 immediately. No done follows. The next start with A=9, B=3 yields Diff=6, Bo=0.
- Exhaustive sweep at WIDTH=4, all 256 A/B pairs back-to-back → every Diff equals (A−B) mod 16 and Bo equals (A<B). Also verify WIDTH=2 with A=1, B=2 → Diff=3, Bo=1.
